// File: rtl/sc_serialtx_pkg.sv
// sc_serialtx_pkg: shared state encoding and constants for the UART-format
// serializer (sc_serialtx) and its bit-period generator.
package sc_serialtx_pkg;

  // 50 MHz / 115200 baud
  localparam int CLKS_PER_BIT_DEF = 434;

  // Level of the serial line between frames and during the stop bit
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/sc_serialtx_baudgen.sv
// sc_serialtx_baudgen: bit-period counter for the serializer. Counts
// 0..CLKS_PER_BIT-1 while enabled and ticks bit_end_o on the last count.
module sc_serialtx_baudgen #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic bit_end_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_end_o = en_i && !clr_i && (cnt_q == CNT_LAST);

  // Next count: clear wins, otherwise advance and wrap at the period end
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Period counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sc_serialtx.sv
// sc_serialtx: serializes the parallel data bus onto one UART-format line
// (start bit, DATAWIDTH data bits LSB first, optional even parity, stop bit).
// A frame is requested by a falling edge on the active-low start strobe.
// Build option: define SC_SERIALTX_PARITY_EN to insert the even-parity bit.
//
//   state     | meaning
//   ST_IDLE   | line high, waiting for a falling edge on start
//   ST_START  | driving the start bit (0)
//   ST_DATA   | driving shift_q[0], one bit per period, LSB first
//   ST_PARITY | driving the stored even-parity bit (parity builds only)
//   ST_STOP   | driving the stop bit (1); done pulses on exit
module sc_serialtx
  import sc_serialtx_pkg::*;
#(
  parameter int DATAWIDTH    = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 SC_SERIALTX_CLOCK_50,
  input  logic                 SC_SERIALTX_RESET_InHigh,
  input  logic                 SC_SERIALTX_start_InLow,
  input  logic [DATAWIDTH-1:0] SC_SERIALTX_data_InBUS,
  output logic                 SC_SERIALTX_tx_Out,
  output logic                 SC_SERIALTX_busy_Out,
  output logic                 SC_SERIALTX_done_Out
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATAWIDTH - 1);

  tx_state_e            state_q;
  logic [DATAWIDTH-1:0] shift_q;
  logic [DATAWIDTH-1:0] shift_d;
  logic [IDX_W-1:0]     idx_q;
  logic                 start_prev_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 accept;
  logic                 bit_end;
`ifdef SC_SERIALTX_PARITY_EN
  logic                 par_q;
`endif

  // Only a fresh falling edge seen in IDLE starts a frame
  assign accept  = (state_q == ST_IDLE) && !SC_SERIALTX_start_InLow && start_prev_q;
  assign shift_d = shift_q >> 1;

  sc_serialtx_baudgen #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baudgen (
    .clk_i     (SC_SERIALTX_CLOCK_50),
    .rst_i     (SC_SERIALTX_RESET_InHigh),
    .clr_i     (accept),
    .en_i      (state_q != ST_IDLE),
    .bit_end_o (bit_end)
  );

  // Frame sequencer with registered line, busy and done outputs
  always_ff @(posedge SC_SERIALTX_CLOCK_50 or posedge SC_SERIALTX_RESET_InHigh) begin
    if (SC_SERIALTX_RESET_InHigh) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      idx_q        <= '0;
      start_prev_q <= 1'b1;
      tx_q         <= LINE_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef SC_SERIALTX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      start_prev_q <= SC_SERIALTX_start_InLow;
      done_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            shift_q <= SC_SERIALTX_data_InBUS;
            idx_q   <= '0;
`ifdef SC_SERIALTX_PARITY_EN
            par_q   <= ^SC_SERIALTX_data_InBUS;
`endif
            state_q <= ST_START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state_q <= ST_DATA;
            tx_q    <= shift_q[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            shift_q <= shift_d;
            idx_q   <= idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
`ifdef SC_SERIALTX_PARITY_EN
              state_q <= ST_PARITY;
              tx_q    <= par_q;
`else
              state_q <= ST_STOP;
              tx_q    <= LINE_IDLE;
`endif
            end else begin
              tx_q <= shift_d[0];
            end
          end
        end
`ifdef SC_SERIALTX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            state_q <= ST_STOP;
            tx_q    <= LINE_IDLE;
          end
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= LINE_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign SC_SERIALTX_tx_Out   = tx_q;
  assign SC_SERIALTX_busy_Out = busy_q;
  assign SC_SERIALTX_done_Out = done_q;

endmodule

// File: tb/tb_sc_serialtx.sv
// tb_sc_serialtx: checks sc_serialtx (DATAWIDTH=8, CLKS_PER_BIT=4) against a
// frame-timeline model: each accepted request starts a timeline whose line
// level at cycle t is bit (t / CLKS_PER_BIT) of the frame image.
module tb_sc_serialtx;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef SC_SERIALTX_PARITY_EN
  localparam int NBITS = DW + 3;
`else
  localparam int NBITS = DW + 2;
`endif
  localparam int FL = NBITS * CPB;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          start_n = 1'b1;
  logic [DW-1:0] data    = '0;
  logic          tx;
  logic          busy;
  logic          done;

  sc_serialtx #(
    .DATAWIDTH    (DW),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .SC_SERIALTX_CLOCK_50     (clk),
    .SC_SERIALTX_RESET_InHigh (rst),
    .SC_SERIALTX_start_InLow  (start_n),
    .SC_SERIALTX_data_InBUS   (data),
    .SC_SERIALTX_tx_Out       (tx),
    .SC_SERIALTX_busy_Out     (busy),
    .SC_SERIALTX_done_Out     (done)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit            m_active = 1'b0;
  int            m_t      = 0;
  bit            m_prev   = 1'b1;
  bit            m_done   = 1'b0;
  logic [DW-1:0] m_word   = '0;
  logic [15:0]   cap      = '0;

  // Bit k of the frame image: start, data LSB first, [parity], stop
  function automatic logic frame_bit(input logic [DW-1:0] w, input int k);
    if (k == 0) return 1'b0;
    if (k <= DW) return w[k-1];
`ifdef SC_SERIALTX_PARITY_EN
    if (k == DW + 1) return ^w;
`endif
    return 1'b1;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_active = 1'b0;
      m_prev   = 1'b1;
      m_done   = 1'b0;
      return;
    end
    m_done = 1'b0;
    if (m_active) begin
      m_t++;
      if (m_t == FL) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end else if (!start_n && m_prev) begin
      m_active = 1'b1;
      m_t      = 0;
      m_word   = data;
    end
    m_prev = start_n;
  endtask

  // One clock: advance the model at the edge, compare at the falling edge
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("tx",   32'(tx),   32'(m_active ? frame_bit(m_word, m_t / CPB) : 1'b1));
    check("busy", 32'(busy), 32'(m_active));
    check("done", 32'(done), 32'(m_done));
    if (m_active && (m_t % CPB) == 1) cap[m_t / CPB] = tx;
  endtask

  task automatic run_frame(input logic [DW-1:0] w, input int hold, input int chg_at,
                           input logic [DW-1:0] chg_val, output int nb, output int nd);
    nb      = 0;
    nd      = 0;
    cap     = '0;
    data    = w;
    start_n = 1'b0;
    for (int i = 0; i < FL + hold + 10; i++) begin
      if (i == hold) start_n = 1'b1;
      if (i == chg_at) data = chg_val;
      cyc();
      nb += int'(busy);
      nd += int'(done);
    end
    start_n = 1'b1;
  endtask

  initial begin
    #(200000 * 20);
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int nd;

    repeat (3) cyc();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      data = DW'($urandom);
      cyc();
    end

    run_frame(8'hA5, 1, -1, 8'h00, nb, nd);
    check("a5_busy_len", 32'(nb), 32'(FL));
    check("a5_done_cnt", 32'(nd), 32'd1);
`ifdef SC_SERIALTX_PARITY_EN
    check("a5_bits", 32'(cap[10:0]), 32'h54A);
`else
    check("a5_bits", 32'(cap[9:0]), 32'h34A);
`endif

    run_frame(8'h3C, 200, -1, 8'h00, nb, nd);
    check("hold_busy_len", 32'(nb), 32'(FL));
    check("hold_done_cnt", 32'(nd), 32'd1);

    run_frame(8'hA5, 1, 12, 8'hFF, nb, nd);
`ifdef SC_SERIALTX_PARITY_EN
    check("churn_bits", 32'(cap[10:0]), 32'h54A);
`else
    check("churn_bits", 32'(cap[9:0]), 32'h34A);
`endif

`ifdef SC_SERIALTX_PARITY_EN
    run_frame(8'h07, 1, -1, 8'h00, nb, nd);
    check("par07_bit", 32'(cap[DW+1]), 32'd1);
    check("par07_len", 32'(nb), 32'(FL));
`endif

    // Spurious edge 10 cycles into a frame, then an edge in the done cycle
    data    = 8'h5A;
    start_n = 1'b0;
    cyc();
    start_n = 1'b1;
    repeat (9) cyc();
    start_n = 1'b0;
    data    = 8'hC3;
    cyc();
    start_n = 1'b1;
    for (int i = 0; i < FL + 5 && !done; i++) cyc();
    check("done_seen", 32'(done), 32'd1);
    start_n = 1'b0;
    data    = 8'h96;
    cyc();
    check("b2b_accept", 32'(busy), 32'd1);
    start_n = 1'b1;
    repeat (FL + 5) cyc();

    // Random request edges and data churn
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) start_n = ~start_n;
      data = DW'($urandom);
      cyc();
    end
    start_n = 1'b1;
    repeat (FL + 5) cyc();

    // Reset in the middle of a data bit that drives the line low
    data    = 8'h00;
    start_n = 1'b0;
    cyc();
    start_n = 1'b1;
    repeat (15) cyc();
    check("pre_rst_tx", 32'(tx), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rst_tx",   32'(tx),   32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (2) cyc();
    rst = 1'b0;
    nd  = 0;
    for (int i = 0; i < FL + 5; i++) begin
      cyc();
      nd += int'(done);
    end
    check("rst_no_done", 32'(nd), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
